// File: rtl/tdsp_data_bus_arb.sv
// rtl/tdsp_data_bus_arb.sv - round-robin core/host arbiter and ready-handshake sequencer for tdsp data RAM
module tdsp_data_bus_arb #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              c_go,
    input  logic              c_read,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic              c_done,
    output logic [DATA_W-1:0] c_rdata,
    input  logic              h_req,
    input  logic              h_read,
    input  logic [ADDR_W-1:0] h_addr,
    input  logic [DATA_W-1:0] h_wdata,
    output logic              h_done,
    output logic [DATA_W-1:0] h_rdata,
    output logic              err,
    output logic              m_en,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic              m_ready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic       OWN_CORE = 1'b0;
    localparam logic       OWN_HOST = 1'b1;
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t     state;
    state_t     state_next;
    logic       owner;
    logic       last_owner;
    logic       lat_read;
    logic [7:0] cnt;

    logic       grant;
    logic       grant_host;
    logic       finish;
    logic       timed_out;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Requests are only looked at in IDLE, so a level still held during DONE cannot regrant.
    always_comb begin
        state_next = state;
        grant      = 1'b0;
        grant_host = 1'b0;
        finish     = 1'b0;
        timed_out  = 1'b0;
        case (state)
            IDLE: begin
                if (c_go || h_req) begin
                    grant      = 1'b1;
                    grant_host = h_req && (!c_go || (last_owner == OWN_CORE));
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (m_ready) begin
                    finish     = 1'b1;
                    state_next = DONE;
                end else if (cnt == CNT_LAST) begin
                    finish     = 1'b1;
                    timed_out  = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            owner      <= OWN_CORE;
            last_owner <= OWN_HOST;
            lat_read   <= 1'b0;
            cnt        <= 8'd0;
            m_en       <= 1'b0;
            m_we       <= 1'b0;
            m_addr     <= '0;
            m_wdata    <= '0;
            c_done     <= 1'b0;
            h_done     <= 1'b0;
            err        <= 1'b0;
            c_rdata    <= '0;
            h_rdata    <= '0;
        end else begin
            c_done <= 1'b0;
            h_done <= 1'b0;
            err    <= 1'b0;
            if (grant) begin
                owner    <= grant_host;
                lat_read <= grant_host ? h_read : c_read;
                m_addr   <= grant_host ? h_addr : c_addr;
                m_wdata  <= grant_host ? h_wdata : c_wdata;
                m_we     <= grant_host ? ~h_read : ~c_read;
                m_en     <= 1'b1;
                cnt      <= 8'd0;
            end else if (state == BUSY) begin
                if (finish) begin
                    m_en       <= 1'b0;
                    m_we       <= 1'b0;
                    last_owner <= owner;
                    err        <= timed_out;
                    c_done     <= (owner == OWN_CORE);
                    h_done     <= (owner == OWN_HOST);
                    // An aborted read leaves the requester's last good data in place.
                    if (!timed_out && lat_read) begin
                        if (owner == OWN_HOST) begin
                            h_rdata <= m_rdata;
                        end else begin
                            c_rdata <= m_rdata;
                        end
                    end
                end else begin
                    cnt <= cnt + 8'd1;
                end
            end
        end
    end

endmodule
